dot_accum: RTL and testbench
============================

# dot_accum

Streaming signed dot-product accumulator that sits directly upstream of the requantizer. It consumes a burst of 8-bit asymmetric-quantized activations and 8-bit signed weights. For each beat it subtracts the activation zero point, multiply-accumulates into an 18-bit bias-initialised accumulator, and presents the 18-bit result on a valid/ready output that drives the requantizer's `idata` directly.

## Interface
- `DATA_W`, 8, activation/weight width
- `ACC_W`, 18, accumulator and output width (matches requantizer input)
- `LEN_W`, 8, burst-length counter width
- `clock` in 1 — single clock, rising edge
- `reset` in 1 — synchronous, active-high
- `start` in 1 — begin a burst; sampled only in IDLE
- `len` in LEN_W — beats in burst, latched on accepted `start`
- `bias` in ACC_W signed — accumulator initial value, latched on `start`
- `act_zp` in DATA_W — activation zero point, latched on `start`
- `in_valid` in 1 / `in_ready` out 1 — input beat handshake
- `act` in DATA_W unsigned — activation
- `wgt` in DATA_W signed — weight
- `out_valid` out 1 / `out_ready` in 1 — result handshake
- `out_data` out ACC_W signed — accumulated result
- `busy` out 1 — high in ACC and OUT
- `ovf` out 1 — sticky saturation flag for current burst

## Operation
- FSM states: IDLE, ACC, OUT.
- IDLE:
  - `start` latches `len`, `bias`, `act_zp`; loads acc = `bias`; clears `ovf` and the beat counter.
  - `len`≠0 → ACC; `len`=0 → OUT with acc = `bias`.
- ACC:
  - `in_ready`=1. Each beat accepted when `in_valid`&`in_ready`.
  - diff = {1'b0,act} − {1'b0,act_zp}, 9-bit signed.
  - prod = diff × wgt, 17-bit signed.
  - acc ← acc + sign-extended prod, computed at 19 bits then reduced to ACC_W per Configuration.
  - Counter increments per accepted beat; the beat with counter = len−1 is the last → OUT.
  - `in_valid` gaps stall; no timeout.
- OUT:
  - `out_valid`=1; `out_data` = acc, held stable until `out_ready`.
  - On the handshake → IDLE.
- `in_ready`=0 in IDLE and OUT; beats offered there are not consumed.
- `start` in ACC/OUT is ignored, not queued.
- `reset` in any state → IDLE next edge; partial burst discarded.
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `busy`=0, `ovf`=0, acc=0, counter=0.

## Timing
- `start` accepted at edge t → `busy`=1 and `in_ready`=1 from t+1.
- Last beat accepted at edge k → `out_valid`=1 from k+1 (1-cycle latency, no multiplier pipeline).
- `len`=0: `out_valid`=1 from t+1.
- Output handshake at edge m → `out_valid`=0 and `busy`=0 from m+1; next `start` accepted at m+1 at earliest.
- Throughput: 1 beat/cycle while `in_valid` held.
- Burst overhead: 2 cycles (start, output).

## Configuration
- `DOT_ACCUM_SAT_EN` defined:
  - Each add clamps to [−131072, 131071]. With `ACC_W`=18, these are −2^(ACC_W−1) and 2^(ACC_W−1)−1.
  - `ovf` is set on any clamp and stays set until the next `start`.
- `DOT_ACCUM_SAT_EN` undefined:
  - Two's-complement wrap modulo 2^ACC_W.
  - `ovf` tied 0.

## Structure
- Package `dot_accum_pkg`: state encoding (IDLE/ACC/OUT), `ACC_MAX`/`ACC_MIN` constants, default widths.
- One sub-module `sat_add`: ACC_W-bit signed adder with 17-bit operand.
  - Outputs sum and clamp flag.
  - Contains the `DOT_ACCUM_SAT_EN` conditional.

## Test plan
- len=1, bias=0, act_zp=1, act=5, wgt=2 → `out_valid` one cycle after beat, `out_data`=8, `ovf`=0.
- len=4, bias=100, act_zp=0, act=10, wgt=−3 every beat, `in_valid` dropped for 2 cycles mid-burst → `out_data`=−20, exactly 4 beats consumed.
- len=0, bias=−7 → `out_valid` at start+1, `out_data`=−7, `in_ready` never asserted.
- len=255, bias=0, act_zp=0, act=255, wgt=127:
  - With macro: `out_data`=131071, `ovf`=1.
  - Without macro: `out_data`=−130433, `ovf`=0.
- `out_ready` low for 3 cycles with `start` pulsed meanwhile → `out_data` stable, `start` ignored, `busy`=1 until handshake.
- `reset` after 2 of 4 beats → all outputs at reset values next cycle; a following len=1, act=3, act_zp=0, wgt=4, bias=0 burst gives `out_data`=12.

Source files
------------

// File: rtl/dot_accum_pkg.sv
// Shared types and constants for the dot-product accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dot_accum_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 18;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    function automatic int acc_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    function automatic int acc_min(input int w);
        return -(1 << (w - 1));
    endfunction

    localparam int ACC_MAX = acc_max(ACC_W_DEF);
    localparam int ACC_MIN = acc_min(ACC_W_DEF);

endpackage

// File: rtl/dot_accum_sat_add.sv
// Signed accumulator adder: saturating when DOT_ACCUM_SAT_EN is defined, else wrapping.
// Latency: combinational.
// Backpressure: none; pure datapath.
module sat_add
    import dot_accum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int OPD_W = 2 * DATA_W_DEF + 1
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [OPD_W-1:0] b,
    output logic signed [ACC_W-1:0] sum,
    output logic                    clamp
);

`ifdef DOT_ACCUM_SAT_EN
    logic [ACC_W:0] wide;

    always_comb begin
        wide  = {a[ACC_W-1], a} + {{(ACC_W + 1 - OPD_W){b[OPD_W-1]}}, b};
        // One guard bit is enough: the two top bits disagree exactly on overflow.
        clamp = wide[ACC_W] ^ wide[ACC_W-1];
        sum   = wide[ACC_W-1:0];
        if (clamp) begin
            sum = wide[ACC_W] ? ACC_W'(acc_min(ACC_W)) : ACC_W'(acc_max(ACC_W));
        end
    end
`else
    assign sum   = a + {{(ACC_W - OPD_W){b[OPD_W-1]}}, b};
    assign clamp = 1'b0;
`endif

endmodule

// File: rtl/dot_accum.sv
// Streaming signed dot-product accumulator (zero-point corrected), optional saturation via DOT_ACCUM_SAT_EN.
// Latency: result valid 1 cycle after the last beat (or after start when len=0).
// Backpressure: in_ready only in ACC; result held on out_data until out_ready.
module dot_accum
    import dot_accum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LEN_W-1:0]         len,
    input  logic signed [ACC_W-1:0]  bias,
    input  logic [DATA_W-1:0]        act_zp,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        act,
    input  logic signed [DATA_W-1:0] wgt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     busy,
    output logic                     ovf
);

    localparam int PROD_W = 2 * DATA_W + 1;

    state_t                    state;
    state_t                    state_nxt;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          cnt;
    logic [DATA_W-1:0]         zp_q;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   acc_sum;
    logic                      clamp;
    logic                      ovf_q;
    logic signed [DATA_W:0]    diff;
    logic signed [PROD_W-1:0]  prod;
    logic                      beat;
    logic                      last;

    assign diff = $signed({1'b0, act}) - $signed({1'b0, zp_q});
    assign prod = PROD_W'(diff) * PROD_W'(wgt);
    assign beat = (state == ST_ACC) && in_valid;
    assign last = (cnt == len_q - LEN_W'(1));

    sat_add #(
        .ACC_W (ACC_W),
        .OPD_W (PROD_W)
    ) u_sat_add (
        .a     (acc),
        .b     (prod),
        .sum   (acc_sum),
        .clamp (clamp)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (len == '0) ? ST_OUT : ST_ACC;
            ST_ACC:  if (beat && last) state_nxt = ST_OUT;
            ST_OUT:  if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_ACC);
        out_valid = (state == ST_OUT);
        busy      = (state != ST_IDLE);
        out_data  = acc;
        ovf       = ovf_q;
    end

    // Burst parameters are captured only on an accepted start so later input changes are harmless.
    always_ff @(posedge clock) begin
        if (reset) begin
            len_q <= '0;
            zp_q  <= '0;
            cnt   <= '0;
            acc   <= '0;
            ovf_q <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            len_q <= len;
            zp_q  <= act_zp;
            cnt   <= '0;
            acc   <= bias;
            ovf_q <= 1'b0;
        end else if (beat) begin
            cnt   <= cnt + LEN_W'(1);
            acc   <= acc_sum;
            ovf_q <= ovf_q | clamp;
        end
    end

endmodule

// File: tb/tb_dot_accum.sv
// Randomised and directed bench for dot_accum with a queue-based scoreboard.
// Expected results come from an integer reference model of the burst arithmetic.
module tb_dot_accum;

    localparam int DW = 8;
    localparam int AW = 18;
    localparam int LW = 8;

`ifdef DOT_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic [LW-1:0]        len;
    logic signed [AW-1:0] bias;
    logic [DW-1:0]        act_zp;
    logic                 in_valid;
    logic                 in_ready;
    logic [DW-1:0]        act;
    logic signed [DW-1:0] wgt;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [AW-1:0] out_data;
    logic                 busy;
    logic                 ovf;

    always #5 clock = ~clock;

    dot_accum dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .bias      (bias),
        .act_zp    (act_zp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .act       (act),
        .wgt       (wgt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .ovf       (ovf)
    );

    typedef struct {
        int data;
        bit ov;
    } exp_t;

    exp_t exp_q[$];
    int   b_act[$];
    int   b_wgt[$];
    int   tests      = 0;
    int   fails      = 0;
    int   consumed   = 0;
    int   outs_seen  = 0;
    int   outs_expct = 0;
    int   last_data  = 0;
    bit   last_ov    = 1'b0;

    function automatic void check(input string name, input longint got, input longint want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endfunction

    function automatic int wrap18(input int v);
        int r;
        r = v & 32'h3FFFF;
        if (r >= 131072) r -= 262144;
        return r;
    endfunction

    // Reference: bias + sum((act - zp) * wgt), clamped per add or wrapped mod 2^18.
    function automatic exp_t model(input int bias_v, input int zp_v);
        exp_t e;
        int   a;
        a    = bias_v;
        e.ov = 1'b0;
        foreach (b_act[i]) begin
            a = a + (b_act[i] - zp_v) * b_wgt[i];
            if (SAT) begin
                if (a > 131071) begin
                    a = 131071;
                    e.ov = 1'b1;
                end else if (a < -131072) begin
                    a = -131072;
                    e.ov = 1'b1;
                end
            end else begin
                a = wrap18(a);
            end
        end
        e.data = a;
        return e;
    endfunction

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            if (in_valid && in_ready) consumed++;
            if (out_valid && out_ready) begin
                outs_seen++;
                last_data = out_data;
                last_ov   = ovf;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e.data);
                    check("sb_ovf", ovf, e.ov);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_burst(input int bias_v, input int zp_v, input int gap_pct,
                             input int gap_at, input int hold);
        int n;
        int guard;
        n = b_act.size();
        exp_q.push_back(model(bias_v, zp_v));
        outs_expct++;
        consumed = 0;
        start  = 1'b1;
        len    = LW'(n);
        bias   = AW'(bias_v);
        act_zp = DW'(zp_v);
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("in_ready_after_start", in_ready, n != 0);
        for (int i = 0; i < n; i++) begin
            if (i == gap_at) begin
                in_valid = 1'b0;
                tick();
                tick();
            end
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                act = DW'($urandom);
                wgt = DW'($urandom);
                tick();
            end
            in_valid = 1'b1;
            act = DW'(b_act[i]);
            wgt = DW'(b_wgt[i]);
            guard = 0;
            while (!in_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (guard >= 20) begin
                check("in_ready_timeout", 0, 1);
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        check("out_valid_latency", out_valid, 1);
        guard = 0;
        while (!out_valid && guard < 300) begin
            tick();
            guard++;
        end
        if (!out_valid) check("out_valid_timeout", 0, 1);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("out_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_hs", out_valid, 0);
        check("busy_after_hs", busy, 0);
        check("beats_consumed", consumed, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit reached, expected bench completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; len = '0; bias = '0; act_zp = '0;
        in_valid = 1'b0; act = '0; wgt = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        reset = 1'b0;
        tick();

        b_act = '{5}; b_wgt = '{2};
        run_burst(0, 1, 0, -1, 0);
        check("single_beat_data", last_data, 8);
        check("single_beat_ovf", last_ov, 0);

        b_act = '{10, 10, 10, 10}; b_wgt = '{-3, -3, -3, -3};
        run_burst(100, 0, 0, 2, 1);
        check("gapped_burst_data", last_data, -20);

        b_act.delete(); b_wgt.delete();
        run_burst(-7, 0, 0, -1, 2);
        check("len0_data", last_data, -7);

        b_act.delete(); b_wgt.delete();
        for (int i = 0; i < 255; i++) begin
            b_act.push_back(255);
            b_wgt.push_back(127);
        end
        run_burst(0, 0, 0, -1, 0);
        check("long_burst_data", last_data, SAT ? 131071 : -130433);
        check("long_burst_ovf", last_ov, SAT ? 1 : 0);

        // Output stall with a start pulse that must be ignored.
        b_act = '{7, 9}; b_wgt = '{3, -2};
        exp_q.push_back(model(50, 4));
        outs_expct++;
        start = 1'b1; len = LW'(2); bias = AW'(50); act_zp = DW'(4);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; act = DW'(b_act[i]); wgt = DW'(b_wgt[i]);
            tick();
        end
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("stall_out_valid", out_valid, 1);
            check("stall_out_data", out_data, 49);
            check("stall_busy", busy, 1);
            start = (c == 1); len = LW'(1); bias = AW'(999); act_zp = DW'(0);
            tick();
        end
        start = 1'b0;
        check("stall_out_data_end", out_data, 49);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_busy_after_hs", busy, 0);
        tick();
        check("start_not_queued_busy", busy, 0);
        check("start_not_queued_in_ready", in_ready, 0);

        // Reset in the middle of a burst.
        start = 1'b1; len = LW'(4); bias = AW'(0); act_zp = DW'(0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; act = DW'(20); wgt = DW'(5);
            tick();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_data", out_data, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ovf", ovf, 0);
        reset = 1'b0;
        tick();
        b_act = '{3}; b_wgt = '{4};
        run_burst(0, 0, 0, -1, 0);
        check("after_rst_data", last_data, 12);

        for (int k = 0; k < 24; k++) begin
            int n;
            int bias_v;
            n = $urandom_range(1, 12);
            b_act.delete(); b_wgt.delete();
            for (int i = 0; i < n; i++) begin
                b_act.push_back($urandom_range(0, 255));
                b_wgt.push_back(int'($urandom_range(0, 255)) - 128);
            end
            case (k % 4)
                0:       bias_v = 131000;
                1:       bias_v = -131000;
                default: bias_v = int'($urandom_range(0, 262143)) - 131072;
            endcase
            run_burst(bias_v, $urandom_range(0, 255), 30, -1, $urandom_range(0, 2));
        end

        tick();
        check("scoreboard_empty", exp_q.size(), 0);
        check("outputs_seen", outs_seen, outs_expct);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
